// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: pops a burst of words from a FIFO and delivers them to a valid/ready
// stream through a 2-entry in-order skid buffer, with credit-based pop throttling.
module fifo_drain_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_W-1:0]      rd_count,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

    state_t                r_state;
    logic [LEN_W-1:0]      r_remaining;
    logic [LEN_W-1:0]      r_rd_count;
    logic [1:0]            r_occ;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic                  w_pop;
    logic [1:0]            w_occ_after_pop;
    logic [2:0]            w_credit;

    assign w_pop           = m_valid && m_ready;
    assign w_occ_after_pop = r_occ - {1'b0, w_pop};
    // Words buffered plus the one in flight, less the one leaving now, must leave room for one more.
    assign w_credit        = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign fifo_rd_en      = r_state == S_READ && !fifo_empty && r_remaining != '0 && w_credit < 3'd2;
    assign m_valid         = r_occ != 2'd0;
    assign m_data          = r_buf0;
    assign busy            = r_state != S_IDLE;
    assign done            = r_state == S_DONE;
    assign rd_count        = r_rd_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_rd_count  <= '0;
            r_occ       <= 2'd0;
            r_inflight  <= 1'b0;
            r_buf0      <= '0;
            r_buf1      <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            r_occ      <= w_occ_after_pop + {1'b0, r_inflight};
            // Incoming word lands in the first slot still free after the head leaves.
            if (r_inflight && w_occ_after_pop == 2'd0)
                r_buf0 <= fifo_rd_data;
            else if (w_pop)
                r_buf0 <= r_buf1;
            if (r_inflight && w_occ_after_pop == 2'd1)
                r_buf1 <= fifo_rd_data;
            if (fifo_rd_en) begin
                r_remaining <= r_remaining - LEN_W'(1);
                r_rd_count  <= r_rd_count + LEN_W'(1);
            end
            case (r_state)
                S_IDLE: if (start) begin
                    r_remaining <= burst_len;
                    r_rd_count  <= '0;
                    r_state     <= burst_len != '0 ? S_READ : S_DONE;
                end
                S_READ: if (fifo_rd_en && r_remaining == LEN_W'(1)) r_state <= S_FLUSH;
                // Leave as soon as the last word is accepted, so done follows it by one cycle.
                S_FLUSH: if (!r_inflight && r_occ == {1'b0, w_pop}) r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/fifo_drain_ctrl.md
FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the FIFO read-data and output-stream width.
REQ-002 The block SHALL have parameter LEN_W, default 8, giving the burst-length and counter width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  single-cycle request to drain one burst.
REQ-007 burst_len  input  LEN_W  number of words to drain, sampled when start is accepted.
REQ-008 busy  output  1  high from start acceptance until the done cycle inclusive.
REQ-009 done  output  1  one-cycle pulse when the burst has been fully delivered downstream.
REQ-010 rd_count  output  LEN_W  words popped from the FIFO in the current or most recent burst.
REQ-011 fifo_empty  input  1  FIFO read-side empty flag.
REQ-012 fifo_rd_en  output  1  FIFO pop strobe.
REQ-013 fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
REQ-014 m_valid  output  1  downstream data valid.
REQ-015 m_data  output  DATA_WIDTH  downstream data.
REQ-016 m_ready  input  1  downstream accept.

Function
REQ-017 The FSM SHALL have states IDLE, READ, FLUSH and DONE.
REQ-018 In IDLE, start=1 SHALL load remaining<=burst_len and rd_count<=0; the FSM SHALL go to READ if burst_len!=0, otherwise to DONE.
REQ-019 start while busy=1 SHALL be ignored, with no effect on counters or state.
REQ-020 fifo_rd_en SHALL be combinational: state==READ and !fifo_empty and remaining!=0 and (occ + inflight - (m_valid&&m_ready)) < 2, where occ is the 0..2 skid-buffer occupancy and inflight is 1 if fifo_rd_en was high last cycle.
REQ-021 Each fifo_rd_en SHALL decrement remaining and increment rd_count in the same edge.
REQ-022 fifo_rd_data SHALL be written into the 2-entry in-order skid buffer at the edge ending the cycle after fifo_rd_en.
REQ-023 With this timing, m_valid SHALL assert no earlier than 2 cycles after the first fifo_rd_en.
REQ-024 m_valid SHALL be high whenever occ>0, and m_data SHALL be the oldest buffered word.
REQ-025 A word SHALL be removed only on m_valid&&m_ready.
REQ-026 While m_valid=1 and m_ready=0, m_data SHALL be held stable.
REQ-027 A simultaneous capture and downstream accept SHALL leave occ unchanged and preserve word order.
REQ-028 No word SHALL be dropped or duplicated.
REQ-029 The buffer SHALL never overflow: the REQ-020 credit rule guarantees occ<=2.
REQ-030 With fifo_empty=0 and m_ready=1 held, the block SHALL sustain one pop per cycle.
REQ-031 fifo_empty=1 in READ SHALL stall pops without leaving READ; there is no timeout.
REQ-032 READ SHALL go to FLUSH when remaining reaches 0.
REQ-033 FLUSH SHALL go to DONE when inflight==0 and occ==0.
REQ-034 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-035 rd_count SHALL hold its final value in IDLE until the next accepted start.
REQ-036 fifo_rd_en SHALL never assert outside READ.
REQ-037 burst_len of 2^LEN_W-1 SHALL be supported; counters SHALL not wrap within a burst.

Reset
REQ-038 On rst=1, regardless of clock, the block SHALL asynchronously reset to: state=IDLE, busy=0, done=0, rd_count=0, remaining=0, occ=0, inflight=0, fifo_rd_en=0, m_valid=0, m_data=0.
REQ-039 Reset mid-burst SHALL discard buffered and in-flight data; a FIFO word popped in the last cycle before reset is lost and not replayed.
REQ-040 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-041 FIFO preloaded 0x11..0x14, start with burst_len=4, m_ready=1 -> fifo_rd_en high 4 consecutive cycles; m_data 0x11,0x12,0x13,0x14 on 4 consecutive cycles starting 2 cycles after the first pop; done 1 cycle after the last transfer; rd_count=4.
REQ-042 burst_len=0 -> done pulses the cycle after start; fifo_rd_en never asserts; rd_count=0.
REQ-043 FIFO holds 8 words, burst_len=6, m_ready=0 for 10 cycles then 1 -> exactly 2 pops before the stall, m_valid=1 with m_data stable at word 0, then 6 in-order transfers and exactly 6 pops total.
REQ-044 fifo_empty toggled 1/0 every 2 cycles, burst_len=5 -> fifo_rd_en only when fifo_empty=0; 5 words delivered in order; busy stays high throughout.
REQ-045 rst asserted 3 cycles into a burst_len=10 drain -> all outputs at reset values immediately, without waiting for a clock edge; a new start with burst_len=2 after release completes normally.
REQ-046 start pulsed again while busy -> ignored; rd_count and the done timing match the original burst only.
